mem_wb: RTL and testbench

MEM_WB -- requirements
Module: mem_wb

---
 rtl/mem_wb.sv | 129 ++++++++++++
 tb/tb_mem_wb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb.sv
// MEM/WB pipeline stage: waits on the data memory, extracts load data
// (sign/zero extension by byte offset) and registers the writeback fields.
module mem_wb #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out_mem,
    input  logic [5:0]  rd_addr_mem,
    input  logic        wb_en_mem,
    input  logic        float_wb_en_mem,
    input  logic [2:0]  is_load_mem,
    input  logic [31:0] dm_rdata,
    input  logic        dm_valid,
    output logic        mem_stall,
    output logic        access_err,
    output logic [5:0]  rd_addr_wb,
    output logic        wb_en_wb,
    output logic        float_wb_en_wb,
    output logic [31:0] wb_data,
    output logic [31:0] fw_from_wb
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    logic        is_load;
    logic        timeout_hit;
    logic        load_done;
    logic [1:0]  off;
    logic [15:0] half;
    logic [7:0]  byte_sel;
    logic [31:0] ld_data;
    logic [31:0] sel_data;

    assign is_load = (is_load_mem != 3'b000);
    assign off     = alu_out_mem[1:0];

    // A valid response on the last wait cycle wins over the timeout.
    assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_LAST) && !dm_valid;

    always_comb begin
        load_done = 1'b0;
        if (state == WAIT)
            load_done = dm_valid || (wait_cnt == CNT_LAST);
        else
            load_done = is_load && dm_valid;
    end

    assign mem_stall  = !rst && ((state == WAIT) || (is_load && !dm_valid));
    assign access_err = timeout_hit;

    always_comb begin
        half     = off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        byte_sel = 8'h00;
        case (off)
            2'd0:    byte_sel = dm_rdata[7:0];
            2'd1:    byte_sel = dm_rdata[15:8];
            2'd2:    byte_sel = dm_rdata[23:16];
            default: byte_sel = dm_rdata[31:24];
        endcase
    end

    always_comb begin
        ld_data = dm_rdata;
        case (is_load_mem)
            3'b010:  ld_data = {{16{half[15]}}, half};
            3'b011:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ld_data = {16'h0000, half};
            3'b101:  ld_data = {24'h000000, byte_sel};
            default: ld_data = dm_rdata;
        endcase
    end

    // An aborted load still retires, carrying zero as its data.
    always_comb begin
        sel_data = alu_out_mem;
        if (is_load)
            sel_data = timeout_hit ? 32'h0 : ld_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            rd_addr_wb     <= 6'd0;
            wb_en_wb       <= 1'b0;
            float_wb_en_wb <= 1'b0;
            wb_data        <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_load && !dm_valid) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (load_done) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (mem_stall && !load_done) begin
                rd_addr_wb     <= 6'd0;
                wb_en_wb       <= 1'b0;
                float_wb_en_wb <= 1'b0;
            end else begin
                rd_addr_wb     <= rd_addr_mem;
                wb_en_wb       <= wb_en_mem;
                float_wb_en_wb <= float_wb_en_mem;
                wb_data        <= sel_data;
            end
        end
    end

    assign fw_from_wb = wb_data;

endmodule

// File: tb/tb_mem_wb.sv
// Bench for mem_wb: directed load/ALU cases with literal expectations plus
// randomized traffic checked every cycle against a cycle-count reference model.
module tb_mem_wb;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out_mem;
    logic [5:0]  rd_addr_mem;
    logic        wb_en_mem;
    logic        float_wb_en_mem;
    logic [2:0]  is_load_mem;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_stall;
    logic        access_err;
    logic [5:0]  rd_addr_wb;
    logic        wb_en_wb;
    logic        float_wb_en_wb;
    logic [31:0] wb_data;
    logic [31:0] fw_from_wb;

    int n_pass  = 0;
    int n_total = 0;

    mem_wb #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .alu_out_mem(alu_out_mem), .rd_addr_mem(rd_addr_mem),
        .wb_en_mem(wb_en_mem), .float_wb_en_mem(float_wb_en_mem),
        .is_load_mem(is_load_mem), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_stall(mem_stall), .access_err(access_err),
        .rd_addr_wb(rd_addr_wb), .wb_en_wb(wb_en_wb),
        .float_wb_en_wb(float_wb_en_wb), .wb_data(wb_data),
        .fw_from_wb(fw_from_wb)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // reference model
    function automatic logic [31:0] extract(input logic [2:0] ld, input logic [31:0] d,
                                            input logic [1:0] off);
        logic [31:0] h;
        logic [31:0] b;
        h = (d >> (16 * int'(off[1]))) & 32'h0000FFFF;
        b = (d >> (8 * int'(off))) & 32'h000000FF;
        case (ld)
            3'd2:    return (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
            3'd3:    return (b >= 32'h80) ? b + 32'hFFFFFF00 : b;
            3'd4:    return h;
            3'd5:    return b;
            default: return d;
        endcase
    endfunction

    int          outstanding;
    logic [5:0]  m_rd;
    logic        m_wb;
    logic        m_fwb;
    logic [31:0] m_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding = 0;
            m_rd = 0; m_wb = 0; m_fwb = 0; m_data = 0;
        end else begin
            if (is_load_mem != 0 && !dm_valid && outstanding < TO) begin
                outstanding++;
                m_rd = 0; m_wb = 0; m_fwb = 0;
            end else begin
                m_rd  = rd_addr_mem;
                m_wb  = wb_en_mem;
                m_fwb = float_wb_en_mem;
                if (is_load_mem == 0)  m_data = alu_out_mem;
                else if (dm_valid)     m_data = extract(is_load_mem, dm_rdata, alu_out_mem[1:0]);
                else                   m_data = 32'h0;
                outstanding = 0;
            end
        end
    end

    // per-cycle compare
    always @(negedge clk) begin
        logic ld;
        logic e_stall;
        logic e_err;
        ld      = (is_load_mem != 0);
        e_stall = !rst && ld && (outstanding > 0 || !dm_valid);
        e_err   = !rst && ld && outstanding == TO && !dm_valid;
        check("mem_stall",      32'(mem_stall),      32'(e_stall));
        check("access_err",     32'(access_err),     32'(e_err));
        check("rd_addr_wb",     32'(rd_addr_wb),     32'(m_rd));
        check("wb_en_wb",       32'(wb_en_wb),       32'(m_wb));
        check("float_wb_en_wb", 32'(float_wb_en_wb), 32'(m_fwb));
        check("wb_data",        wb_data,             m_data);
        check("fw_from_wb",     fw_from_wb,          m_data);
    end

    // driver
    int stall_cnt;
    int err_cnt;
    int err_k;

    task automatic do_op(input logic [2:0] ld, input logic [31:0] alu, input logic [5:0] rd,
                         input logic wb, input logic fwb, input int wait_n, input logic [31:0] data);
        int  k;
        bit  done;
        stall_cnt = 0; err_cnt = 0; err_k = -1;
        alu_out_mem = alu; rd_addr_mem = rd; wb_en_mem = wb;
        float_wb_en_mem = fwb; is_load_mem = ld;
        k = 0;
        forever begin
            if (ld == 0) begin
                dm_valid = 1'($urandom_range(0, 1));
                dm_rdata = $urandom;
                done = 1;
            end else begin
                dm_valid = (k == wait_n);
                dm_rdata = (k == wait_n) ? data : $urandom;
                done = (k == wait_n) || (k == TO);
            end
            @(negedge clk);
            stall_cnt += int'(mem_stall);
            if (access_err) begin err_cnt++; err_k = k; end
            @(posedge clk); #1;
            if (done) break;
            k++;
        end
    endtask

    initial begin
        rst = 1'b1;
        alu_out_mem = 0; rd_addr_mem = 0; wb_en_mem = 0; float_wb_en_mem = 0;
        is_load_mem = 0; dm_rdata = 0; dm_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_wb_data", wb_data, 32'h0);
        check("reset_stall", 32'(mem_stall), 32'h0);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        do_op(3'd0, 32'h12345678, 6'd5, 1, 0, 0, 0);
        check("alu_data", wb_data, 32'h12345678);
        check("alu_rd", 32'(rd_addr_wb), 32'd5);
        check("alu_wben", 32'(wb_en_wb), 32'd1);
        check("alu_stall", 32'(stall_cnt), 32'd0);

        do_op(3'd3, 32'h1002, 6'd7, 1, 0, 0, 32'h80FF7F01);
        check("lb_off2", wb_data, 32'hFFFFFFFF);
        do_op(3'd3, 32'h1003, 6'd7, 1, 0, 0, 32'h80FF7F01);
        check("lb_off3", wb_data, 32'hFFFFFF80);
        do_op(3'd5, 32'h1003, 6'd7, 1, 0, 0, 32'h80FF7F01);
        check("lbu_off3", wb_data, 32'h00000080);
        check("lb_nostall", 32'(stall_cnt), 32'd0);

        do_op(3'd2, 32'h2002, 6'd8, 1, 0, 0, 32'h80017FFE);
        check("lh_off2", wb_data, 32'hFFFF8001);
        do_op(3'd4, 32'h2002, 6'd8, 1, 0, 0, 32'h80017FFE);
        check("lhu_off2", wb_data, 32'h00008001);
        do_op(3'd2, 32'h2000, 6'd8, 1, 0, 0, 32'h80017FFE);
        check("lh_off0", wb_data, 32'h00007FFE);

        do_op(3'd1, 32'h3001, 6'd9, 1, 0, 3, 32'hDEADBEEF);
        check("lw3_stall", 32'(stall_cnt), 32'd4);
        check("lw3_data", wb_data, 32'hDEADBEEF);
        check("lw3_wben", 32'(wb_en_wb), 32'd1);

        do_op(3'd1, 32'h4000, 6'd10, 1, 0, 99, 0);
        check("to_err_cnt", 32'(err_cnt), 32'd1);
        check("to_err_k", 32'(err_k), 32'd16);
        check("to_stall", 32'(stall_cnt), 32'd17);
        check("to_data", wb_data, 32'h0);

        do_op(3'd6, 32'h4000, 6'd33, 0, 1, 16, 32'hA5A5_5A5A);
        check("to_prio_err", 32'(err_cnt), 32'd0);
        check("to_prio_data", wb_data, 32'hA5A55A5A);
        check("flw_fwb", 32'(float_wb_en_wb), 32'd1);

        do_op(3'd1, 32'h5000, 6'd11, 0, 0, 2, 32'h01020304);
        check("noen_wben", 32'(wb_en_wb), 32'd0);
        check("noen_data", wb_data, 32'h01020304);

        // reset in the second WAIT cycle of a load that never returns
        do_op(3'd0, 32'hCAFEF00D, 6'd12, 1, 0, 0, 0);
        alu_out_mem = 32'h6000; rd_addr_mem = 6'd13; wb_en_mem = 1;
        is_load_mem = 3'd1; dm_valid = 0;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        is_load_mem = 3'd0;
        #1;
        check("rst_data", wb_data, 32'h0);
        check("rst_fw", fw_from_wb, 32'h0);
        check("rst_wben", 32'(wb_en_wb), 32'h0);
        check("rst_rd", 32'(rd_addr_wb), 32'h0);
        check("rst_stall", 32'(mem_stall), 32'h0);
        check("rst_err", 32'(access_err), 32'h0);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        do_op(3'd0, 32'h0BADF00D, 6'd14, 1, 0, 0, 0);
        check("post_rst_data", wb_data, 32'h0BADF00D);
        check("post_rst_rd", 32'(rd_addr_wb), 32'd14);

        for (int i = 0; i < 300; i++) begin
            int r;
            int w;
            logic [2:0] ld;
            r  = $urandom_range(0, 19);
            w  = (r < 10) ? 0 : (r < 17) ? $urandom_range(1, 4) : (r < 18) ? $urandom_range(12, 16) : 99;
            ld = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            do_op(ld, $urandom, 6'($urandom), 1'($urandom), 1'($urandom), w, $urandom);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
